// File: rtl/alu_pkg.sv
// Shared opcode and state definitions for the accumulator ALU and its sequencer.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_HLT  = 4'b0000,
    OP_SKZ  = 4'b0001,
    OP_ADD  = 4'b0010,
    OP_AND  = 4'b0011,
    OP_XOR  = 4'b0100,
    OP_LDA  = 4'b0101,
    OP_STO  = 4'b0110,
    OP_JMP  = 4'b0111,
    OP_SUB  = 4'b1000,
    OP_ADC  = 4'b1001,
    OP_OR   = 4'b1010,
    OP_SHL  = 4'b1011,
    OP_SHR  = 4'b1100,
    OP_MUL  = 4'b1101,
    OP_RSV0 = 4'b1110,
    OP_RSV1 = 4'b1111
  } op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_e;

  // Every opcode at or above this value is reserved and behaves as HLT.
  localparam logic [3:0] OP_RSV_BASE = 4'b1110;

  function automatic logic is_reserved(input logic [3:0] op);
    return op >= OP_RSV_BASE;
  endfunction

endpackage

// File: rtl/alu_acc_seq_if.sv
// Decoder-to-ALU op bus plus the accumulator/flag result bus.
// Handshake: an op transfers on a rising clk edge where in_valid && in_ready; in_ready is
// high only when the ALU is idle, ops offered while it is low are dropped (no queueing), and
// out_valid is a one-cycle pulse marking acc/flags/skip as the result of a completed op.
interface alu_acc_seq_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic [WIDTH-1:0] data;
  logic [WIDTH-1:0] acc;
  logic             zero;
  logic             neg;
  logic             carry;
  logic             ovf;
  logic             out_valid;
  logic             skip;

  modport master (
    output in_valid, op, data,
    input  in_ready, acc, zero, neg, carry, ovf, out_valid, skip
  );

  modport slave (
    input  in_valid, op, data,
    output in_ready, acc, zero, neg, carry, ovf, out_valid, skip
  );
endinterface

// File: rtl/alu_mul_seq.sv
// Iterative shift-add multiplier: one partial-product step per clock, WIDTH steps total.
// product presents the finished result combinationally in the cycle done is high.
module alu_mul_seq #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic                 busy_q, busy_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d;
  logic [2*WIDTH-1:0]   step_prod;

  always_comb begin
    busy_d    = busy_q;
    cnt_d     = cnt_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    prod_d    = prod_q;
    step_prod = prod_q + (mplier_q[0] ? mcand_q : '0);
    if (start) begin
      busy_d   = 1'b1;
      cnt_d    = '0;
      mcand_d  = {{WIDTH{1'b0}}, a};
      mplier_d = b;
      prod_d   = '0;
    end else if (busy_q) begin
      prod_d   = step_prod;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 1'b1;
      if (cnt_q == LAST) begin
        busy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
    end else begin
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
    end
  end

  assign done    = busy_q && (cnt_q == LAST);
  assign product = step_prod;

endmodule

// File: rtl/alu_acc_seq.sv
// Accumulator ALU: owns acc, carry/ovf flags and the skip-on-zero decision.
// Single-cycle ops retire at the accepting edge; MUL holds the bus for WIDTH cycles.
module alu_acc_seq
  import alu_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter bit MUL_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  alu_acc_seq_if.slave bus,
  output state_e      dbg_state
);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic               carry_q, carry_d;
  logic               ovf_q, ovf_d;
  logic               out_valid_q, out_valid_d;
  logic               skip_q, skip_d;

  op_e                op_eff;
  logic               cin;
  logic [WIDTH:0]     add_res;
  logic [WIDTH:0]     sub_res;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_product;

  assign op_eff  = is_reserved(bus.op) ? OP_HLT : op_e'(bus.op);
  assign cin     = (op_eff == OP_ADC) && carry_q;
  assign add_res = {1'b0, acc_q} + {1'b0, bus.data} + {{WIDTH{1'b0}}, cin};
  assign sub_res = {1'b0, acc_q} - {1'b0, bus.data};

  generate
    if (MUL_EN) begin : g_mul
      logic mul_start;
      assign mul_start = bus.in_valid && (state_q == ST_IDLE) && (op_eff == OP_MUL);
      alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .a       (acc_q),
        .b       (bus.data),
        .done    (mul_done),
        .product (mul_product)
      );
    end else begin : g_nomul
      assign mul_done    = 1'b0;
      assign mul_product = '0;
    end
  endgenerate

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    carry_d     = carry_q;
    ovf_d       = ovf_q;
    out_valid_d = 1'b0;
    skip_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          out_valid_d = 1'b1;
          case (op_eff)
            OP_SKZ: skip_d = (acc_q == '0);
            OP_ADD, OP_ADC: begin
              acc_d   = add_res[WIDTH-1:0];
              carry_d = add_res[WIDTH];
              ovf_d   = (acc_q[WIDTH-1] == bus.data[WIDTH-1]) &&
                        (add_res[WIDTH-1] != acc_q[WIDTH-1]);
            end
            OP_SUB: begin
              acc_d   = sub_res[WIDTH-1:0];
              carry_d = ~sub_res[WIDTH];
              ovf_d   = (acc_q[WIDTH-1] != bus.data[WIDTH-1]) &&
                        (sub_res[WIDTH-1] != acc_q[WIDTH-1]);
            end
            OP_AND: begin acc_d = acc_q & bus.data; ovf_d = 1'b0; end
            OP_XOR: begin acc_d = acc_q ^ bus.data; ovf_d = 1'b0; end
            OP_OR:  begin acc_d = acc_q | bus.data; ovf_d = 1'b0; end
            OP_LDA: begin acc_d = bus.data;         ovf_d = 1'b0; end
            OP_SHL: begin
              acc_d   = {acc_q[WIDTH-2:0], 1'b0};
              carry_d = acc_q[WIDTH-1];
              ovf_d   = acc_q[WIDTH-1] ^ acc_q[WIDTH-2];
            end
            OP_SHR: begin
              acc_d   = {1'b0, acc_q[WIDTH-1:1]};
              carry_d = acc_q[0];
              ovf_d   = 1'b0;
            end
            OP_MUL: begin
              // Without a multiplier MUL retires immediately as a no-change op.
              if (MUL_EN) begin
                state_d     = ST_MUL;
                out_valid_d = 1'b0;
              end
            end
            default: ;
          endcase
        end
      end
      ST_MUL: begin
        if (mul_done) begin
          acc_d       = mul_product[WIDTH-1:0];
          carry_d     = |mul_product[2*WIDTH-1:WIDTH];
          ovf_d       = 1'b0;
          out_valid_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      skip_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      carry_q     <= carry_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      skip_q      <= skip_d;
    end
  end

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.acc       = acc_q;
  assign bus.zero      = (acc_q == '0);
  assign bus.neg       = acc_q[WIDTH-1];
  assign bus.carry     = carry_q;
  assign bus.ovf       = ovf_q;
  assign bus.out_valid = out_valid_q;
  assign bus.skip      = skip_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_alu_acc_seq.sv
// Directed bench for alu_acc_seq: driver pushes hand-computed results, a monitor pops them
// on every out_valid; a second instance with MUL_EN=0 checks MUL-as-HLT.
module tb_alu_acc_seq;
  import alu_pkg::*;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  alu_acc_seq_if #(.WIDTH(W)) bus8 ();
  alu_acc_seq_if #(.WIDTH(W)) bus_nm ();
  state_e st8, st_nm;

  alu_acc_seq #(.WIDTH(W), .MUL_EN(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bus8), .dbg_state(st8)
  );
  alu_acc_seq #(.WIDTH(W), .MUL_EN(1'b0)) u_nomul (
    .clk(clk), .rst_n(rst_n), .bus(bus_nm), .dbg_state(st_nm)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  int n_ov    = 0;
  int last_ov_cyc = -10;
  int prev_ov_cyc = -10;
  logic [W+4:0] exp_q[$];

  // Packed result: {acc, carry, ovf, skip, zero, neg}
  function automatic logic [W+4:0] mk(input logic [W-1:0] a, input logic c, input logic o,
                                      input logic s);
    return {a, c, o, s, (a == '0), a[W-1]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [W+4:0] act;
    logic [W+4:0] exp;
    if (rst_n && bus8.out_valid) begin
      n_ov++;
      prev_ov_cyc = last_ov_cyc;
      last_ov_cyc = cyc;
      act = {bus8.acc, bus8.carry, bus8.ovf, bus8.skip, bus8.zero, bus8.neg};
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_out_valid: got {acc,c,o,s,z,n}=0x%0h with nothing expected", act);
      end else begin
        exp = exp_q.pop_front();
        if (act !== exp) begin
          n_fail++;
          $display("FAIL result@cyc%0d: got {acc,c,o,s,z,n}=0x%0h expected 0x%0h", cyc, act, exp);
        end
      end
    end
    if (rst_n && bus8.skip && !bus8.out_valid) begin
      n_tests++;
      n_fail++;
      $display("FAIL skip_without_valid: got skip=1 out_valid=0 expected skip=0");
    end
  end

  // ---------------- driver ----------------
  task automatic send(input logic [3:0] op, input logic [W-1:0] d, input logic [W+4:0] e,
                      input bit push = 1'b1);
    int waited = 0;
    while (!bus8.in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!bus8.in_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: got in_ready=0 for %0d cycles expected 1", waited);
      return;
    end
    bus8.in_valid = 1'b1;
    bus8.op       = op;
    bus8.data     = d;
    @(posedge clk);
    if (push) exp_q.push_back(e);
    #1;
    bus8.in_valid = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int busy_cnt;
    int ov_before;
    int waited;

    bus8.in_valid   = 1'b0; bus8.op   = 4'h0; bus8.data   = '0;
    bus_nm.in_valid = 1'b0; bus_nm.op = 4'h0; bus_nm.data = '0;

    // Test 1: reset held while an op is presented
    repeat (2) @(posedge clk);
    #1;
    bus8.in_valid = 1'b1; bus8.op = OP_LDA; bus8.data = 8'h55;
    repeat (2) @(posedge clk);
    #1;
    bus8.in_valid = 1'b0;
    @(negedge clk);
    check("rst_acc",       32'(bus8.acc),       32'h00);
    check("rst_zero",      32'(bus8.zero),      32'h1);
    check("rst_neg",       32'(bus8.neg),       32'h0);
    check("rst_carry",     32'(bus8.carry),     32'h0);
    check("rst_ovf",       32'(bus8.ovf),       32'h0);
    check("rst_in_ready",  32'(bus8.in_ready),  32'h1);
    check("rst_out_valid", 32'(bus8.out_valid), 32'h0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Test 2: signed overflow on back-to-back ops
    send(OP_LDA, 8'h7F, mk(8'h7F, 1'b0, 1'b0, 1'b0));
    send(OP_ADD, 8'h01, mk(8'h80, 1'b0, 1'b1, 1'b0));
    @(negedge clk);
    #1;
    check("b2b_valid_gap", 32'(last_ov_cyc - prev_ov_cyc), 32'd1);

    // Test 3: carry chain and borrow
    send(OP_LDA, 8'hFF, mk(8'hFF, 1'b0, 1'b0, 1'b0));
    send(OP_ADD, 8'h01, mk(8'h00, 1'b1, 1'b0, 1'b0));
    send(OP_ADC, 8'h00, mk(8'h01, 1'b0, 1'b0, 1'b0));
    send(OP_SUB, 8'h02, mk(8'hFF, 1'b0, 1'b0, 1'b0));
    send(OP_LDA, 8'h80, mk(8'h80, 1'b0, 1'b0, 1'b0));
    send(OP_SUB, 8'h01, mk(8'h7F, 1'b1, 1'b1, 1'b0));
    send(OP_ADC, 8'h00, mk(8'h80, 1'b0, 1'b1, 1'b0));

    // Test 4: multiply, busy window and ignored offers
    send(OP_LDA, 8'h0C, mk(8'h0C, 1'b0, 1'b0, 1'b0));
    send(OP_MUL, 8'h0B, mk(8'h84, 1'b0, 1'b0, 1'b0));
    busy_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!bus8.in_ready) busy_cnt++;
      bus8.in_valid = (i >= 2 && i <= 4);
      bus8.op       = OP_ADD;
      bus8.data     = 8'h01;
    end
    bus8.in_valid = 1'b0;
    check("mul_busy_cycles", 32'(busy_cnt), 32'd8);
    send(OP_LDA, 8'h10, mk(8'h10, 1'b0, 1'b0, 1'b0));
    send(OP_MUL, 8'h20, mk(8'h00, 1'b1, 1'b0, 1'b0));

    // Test 5: skip, shifts and logic ops
    send(OP_LDA, 8'h00, mk(8'h00, 1'b1, 1'b0, 1'b0));
    send(OP_SKZ, 8'h00, mk(8'h00, 1'b1, 1'b0, 1'b1));
    send(OP_LDA, 8'h05, mk(8'h05, 1'b1, 1'b0, 1'b0));
    send(OP_SKZ, 8'h00, mk(8'h05, 1'b1, 1'b0, 1'b0));
    send(OP_LDA, 8'h81, mk(8'h81, 1'b1, 1'b0, 1'b0));
    send(OP_SHL, 8'h00, mk(8'h02, 1'b1, 1'b1, 1'b0));
    send(OP_SHR, 8'h00, mk(8'h01, 1'b0, 1'b0, 1'b0));
    send(OP_OR,  8'h80, mk(8'h81, 1'b0, 1'b0, 1'b0));
    send(OP_XOR, 8'hFF, mk(8'h7E, 1'b0, 1'b0, 1'b0));
    send(OP_AND, 8'h0F, mk(8'h0E, 1'b0, 1'b0, 1'b0));
    send(OP_HLT, 8'hAA, mk(8'h0E, 1'b0, 1'b0, 1'b0));
    send(4'hE,   8'hAA, mk(8'h0E, 1'b0, 1'b0, 1'b0));
    send(4'hF,   8'hAA, mk(8'h0E, 1'b0, 1'b0, 1'b0));
    send(OP_STO, 8'hAA, mk(8'h0E, 1'b0, 1'b0, 1'b0));
    send(OP_JMP, 8'hAA, mk(8'h0E, 1'b0, 1'b0, 1'b0));

    // Test 6: reset three cycles into MUL aborts it
    send(OP_LDA, 8'h03, mk(8'h03, 1'b0, 1'b0, 1'b0));
    send(OP_MUL, 8'h05, '0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_acc",       32'(bus8.acc),       32'h00);
    check("abort_zero",      32'(bus8.zero),      32'h1);
    check("abort_in_ready",  32'(bus8.in_ready),  32'h1);
    check("abort_out_valid", 32'(bus8.out_valid), 32'h0);
    check("abort_state",     32'(st8),            32'(ST_IDLE));
    ov_before = n_ov;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    #1;
    check("abort_no_out_valid", 32'(n_ov - ov_before), 32'd0);

    // Test 7: MUL_EN=0 instance treats MUL as HLT
    @(posedge clk);
    #1;
    bus_nm.in_valid = 1'b1; bus_nm.op = OP_LDA; bus_nm.data = 8'h0C;
    @(posedge clk);
    #1;
    bus_nm.op = OP_MUL; bus_nm.data = 8'h0B;
    @(posedge clk);
    #1;
    bus_nm.in_valid = 1'b0;
    check("nomul_out_valid", 32'(bus_nm.out_valid), 32'h1);
    check("nomul_acc",       32'(bus_nm.acc),       32'h0C);
    check("nomul_carry",     32'(bus_nm.carry),     32'h0);
    check("nomul_in_ready",  32'(bus_nm.in_ready),  32'h1);
    @(posedge clk);
    #1;
    check("nomul_pulse_end", 32'(bus_nm.out_valid), 32'h0);

    // Drain
    waited = 0;
    while (exp_q.size() != 0 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_acc_seq.md
Name: alu_acc_seq

Overview:
- Parametrised accumulator ALU for the simple-CPU datapath. Successor of the 8-bit combinational ALU.
- Owns the accumulator register, the carry/overflow flags and the skip-on-zero decision.
- Adds subtract, add-with-carry, OR, shifts, and a multi-cycle shift-add multiply.
- Sits between the instruction decoder, which issues ops over a valid/ready handshake, and the control FSM, which consumes out_valid/skip.

Parameters:
WIDTH, 8, data/accumulator width (>=4)
MUL_EN, 1, 1 = include multiplier; 0 = MUL opcode executes as NOP

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  op/data presented
in_ready  out  1  block can accept (state IDLE)
op  in  4  opcode (see Behaviour)
data  in  WIDTH  operand
acc  out  WIDTH  accumulator register
zero  out  1  acc == 0 (combinational from acc)
neg  out  1  acc[WIDTH-1]
carry  out  1  registered carry flag
ovf  out  1  registered signed-overflow flag
out_valid  out  1  one-cycle pulse: acc/flags reflect a just-completed op
skip  out  1  pulse with out_valid when completed op was SKZ and acc == 0

Behaviour:
- Reset (async, rst_n=0): acc=0, carry=0, ovf=0, out_valid=0, skip=0, state=IDLE. Hence in_ready=1, zero=1, neg=0.
- Accept: rising edge with in_valid && in_ready. in_valid is ignored while in_ready=0; no queueing.
- Single-cycle ops:
  - acc/carry/ovf update at the accepting edge.
  - out_valid=1 for the following cycle.
  - Back-to-back accepts are allowed every cycle; each uses the acc produced by the previous op.
- Opcodes:
  - 0000 HLT: no change.
  - 0001 SKZ: no change; skip = (acc==0).
  - 0010 ADD: acc+=data; carry=carry-out; ovf=signed overflow.
  - 0011 AND: acc&=data; ovf=0; carry kept.
  - 0100 XOR: acc^=data; ovf=0; carry kept.
  - 0101 LDA: acc=data; ovf=0; carry kept.
  - 0110 STO: no change.
  - 0111 JMP: no change.
  - 1000 SUB: acc-=data; carry=1 if no borrow (acc>=data unsigned); ovf=signed overflow.
  - 1001 ADC: acc+=data+carry; carry and ovf as ADD.
  - 1010 OR: acc|=data; ovf=0; carry kept.
  - 1011 SHL: acc<<1, LSB=0; carry=old MSB; ovf=old MSB^new MSB.
  - 1100 SHR: logical acc>>1; carry=old LSB; ovf=0.
  - 1101 MUL: see below.
  - 1110, 1111: reserved, execute as HLT.
- "No change" ops still pulse out_valid.
- Arithmetic: computed at WIDTH+1 bits; acc takes the low WIDTH bits.
- MUL FSM, states IDLE and MUL:
  - IDLE→MUL on accepting MUL. Latch multiplicand=acc and multiplier=data; clear the 2*WIDTH partial product.
  - In MUL: in_ready=0. One shift-add step per cycle, tracked by a counter 0..WIDTH-1.
  - On the WIDTH-th edge after acceptance: acc = low WIDTH bits of product; carry = (high half != 0); ovf=0; return to IDLE.
  - out_valid pulses the next cycle; the next op can be accepted in that same cycle.
  - Latency: WIDTH cycles to result, single-cycle ops: 1.
- MUL_EN=0: no multiplier logic; MUL executes as HLT.
- Reset mid-MUL: abort, apply reset values; no out_valid, no acc write.
- skip: only ever 1 together with out_valid; evaluated on acc at completion (SKZ does not modify acc).

Decomposition:
- Package alu_pkg:
  - 4-bit opcode enum, values above.
  - FSM state enum {IDLE, MUL}.
  - Helper constant for reserved opcodes.
- Sub-module alu_mul_seq (WIDTH):
  - Interface: start, a, b, done, product[2*WIDTH-1:0].
  - Iterative shift-add multiplier with its own counter; instantiated only under MUL_EN.

Test Plan (WIDTH=8):
1. Hold rst_n=0 mid-operation, release → acc=0x00, zero=1, carry=0, ovf=0, in_ready=1, out_valid=0.
2. LDA 0x7F, ADD 0x01 back-to-back → acc=0x80, neg=1, ovf=1, carry=0; out_valid on 2 consecutive cycles.
3. LDA 0xFF, ADD 0x01 → acc=0x00, carry=1, zero=1. Then ADC 0x00 → acc=0x01, carry=0. Then SUB 0x02 → acc=0xFF, carry=0, ovf=0.
4. LDA 0x0C, MUL 0x0B → in_ready=0 for exactly 8 cycles; ADD pulses on in_valid during busy are ignored; acc=0x84, carry=0, then out_valid. LDA 0x10, MUL 0x20 → acc=0x00, carry=1, zero=1.
5. LDA 0x00, SKZ → skip=1 with out_valid. LDA 0x05, SKZ → skip=0, acc stays 0x05. SHL on 0x81 → acc=0x02, carry=1, ovf=1.
6. Assert rst_n=0 three cycles into MUL → acc=0, state IDLE, in_ready=1, no out_valid afterwards. Repeat test 4 with MUL_EN=0 → MUL behaves as HLT, acc=0x0C in 1 cycle.
